countdown_alarm: RTL

Parametrised countdown timer and alarm for LIMITED game mode. Owns the remaining-time counter and sub-second phase internally (no external seconds/remainder inputs), supports pause/restart, and produces a three-stage accelerating warning beep, a post-expiry alarm burst and the red-ramp score colour. Sits between the game-control FSM and the buzzer/VGA score renderer.

---
 rtl/countdown_alarm_pkg.sv | 19 +
 rtl/countdown_alarm_beep_pattern.sv | 39 +++
 rtl/countdown_alarm.sv | 132 +++++++++++++
 3 files changed

// File: rtl/countdown_alarm_pkg.sv
// rtl/countdown_alarm_pkg.sv - shared state encodings and default timing for the countdown alarm
package countdown_alarm_pkg;

    typedef logic [1:0] cd_state_t;

    localparam cd_state_t CD_IDLE   = 2'd0;
    localparam cd_state_t CD_RUN    = 2'd1;
    localparam cd_state_t CD_PAUSED = 2'd2;
    localparam cd_state_t CD_DONE   = 2'd3;

    localparam int LIMITED_TIME = 60;
    localparam int BEEP_LIMIT   = 10;
    localparam int BEEP_ONE     = 6;
    localparam int BEEP_TWO     = 3;

    localparam logic [11:0] COLOR_SAFE    = 12'h0F6;
    localparam logic [11:0] COLOR_EXPIRED = 12'hF06;

endpackage

// File: rtl/countdown_alarm_beep_pattern.sv
// rtl/countdown_alarm_beep_pattern.sv - warning-beep stage select and phase pattern match
module beep_pattern
    import countdown_alarm_pkg::*;
#(
    parameter int SEC_W      = 10,
    parameter int PH_W       = 3,
    parameter int WARN_SEC   = BEEP_LIMIT,
    parameter int STAGE1_SEC = BEEP_ONE,
    parameter int STAGE2_SEC = BEEP_TWO
) (
    input  logic [SEC_W-1:0] time_left,
    input  logic [PH_W-1:0]  phase,
    output logic             hit
);

    localparam logic [SEC_W-1:0] WARN_T = SEC_W'(WARN_SEC);
    localparam logic [SEC_W-1:0] S1_T   = SEC_W'(STAGE1_SEC);
    localparam logic [SEC_W-1:0] S2_T   = SEC_W'(STAGE2_SEC);

    generate
        if (!(STAGE2_SEC <= STAGE1_SEC && STAGE1_SEC <= WARN_SEC) || PH_W < 2) begin : g_bad_cfg
            $error("beep_pattern: stage thresholds out of order or phase too narrow");
        end
    endgenerate

    // Slow stage fires on the last phase of the second, faster stages every 4th / 2nd phase.
    always_comb begin
        hit = 1'b0;
        if (time_left < WARN_T) begin
            if (time_left >= S1_T)
                hit = &phase;
            else if (time_left >= S2_T)
                hit = &phase[1:0];
            else
                hit = phase[0];
        end
    end

endmodule

// File: rtl/countdown_alarm.sv
// rtl/countdown_alarm.sv - limited-mode countdown timer with pause, warning beeps, expiry alarm and score colour
module countdown_alarm
    import countdown_alarm_pkg::*;
#(
    parameter int SEC_W       = 10,
    parameter int LIMIT       = LIMITED_TIME,
    parameter int TICK_DIV    = 8,
    parameter int WARN_SEC    = BEEP_LIMIT,
    parameter int STAGE1_SEC  = BEEP_ONE,
    parameter int STAGE2_SEC  = BEEP_TWO,
    parameter int ALARM_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             win,
    input  logic             mute,
    output logic [SEC_W-1:0] time_left,
    output logic             expired,
    output logic             done,
    output logic             beep,
    output logic [11:0]      score_color
);

    localparam int PH_W = $clog2(TICK_DIV);
    localparam int AL_W = $clog2(ALARM_TICKS + 1);

    localparam logic [SEC_W-1:0] LIMIT_T = SEC_W'(LIMIT);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(TICK_DIV - 1);
    localparam logic [AL_W-1:0]  ALARM_T = AL_W'(ALARM_TICKS);

    cd_state_t       state;
    logic [PH_W-1:0] phase;
    logic [AL_W-1:0] alarm_cnt;
    logic            alarmed;
    logic            beep_q;
    logic            hit;
    logic            beep_act;

    beep_pattern #(
        .SEC_W      (SEC_W),
        .PH_W       (PH_W),
        .WARN_SEC   (WARN_SEC),
        .STAGE1_SEC (STAGE1_SEC),
        .STAGE2_SEC (STAGE2_SEC)
    ) u_beep_pattern (
        .time_left (time_left),
        .phase     (phase),
        .hit       (hit)
    );

    always_comb begin
        beep_act = 1'b0;
        case (state)
            CD_RUN:  beep_act = hit;
            CD_DONE: beep_act = alarmed && (alarm_cnt != '0);
            default: beep_act = 1'b0;
        endcase
    end

    // alarmed separates expiry from a win, which both end in DONE but sound and colour differently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CD_IDLE;
            time_left <= LIMIT_T;
            phase     <= '0;
            alarm_cnt <= '0;
            alarmed   <= 1'b0;
            expired   <= 1'b0;
            beep_q    <= 1'b1;
        end else begin
            expired <= 1'b0;
            beep_q  <= ~beep_act;
            if (start) begin
                state     <= CD_RUN;
                time_left <= LIMIT_T;
                phase     <= '0;
                alarm_cnt <= '0;
                alarmed   <= 1'b0;
            end else begin
                case (state)
                    CD_RUN: begin
                        if (win) begin
                            state   <= CD_DONE;
                            alarmed <= 1'b0;
                        end else if (pause) begin
                            state <= CD_PAUSED;
                        end else if (tick) begin
                            phase <= phase + PH_W'(1);
                            if (phase == PH_LAST && time_left != '0) begin
                                time_left <= time_left - SEC_W'(1);
                                if (time_left == SEC_W'(1)) begin
                                    state     <= CD_DONE;
                                    expired   <= 1'b1;
                                    alarm_cnt <= ALARM_T;
                                    alarmed   <= 1'b1;
                                end
                            end
                        end
                    end
                    CD_PAUSED: begin
                        if (win) begin
                            state   <= CD_DONE;
                            alarmed <= 1'b0;
                        end else if (!pause) begin
                            state <= CD_RUN;
                        end
                    end
                    CD_DONE: begin
                        if (tick && alarm_cnt != '0)
                            alarm_cnt <= alarm_cnt - AL_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done = (state == CD_DONE);
    assign beep = beep_q | mute;

    always_comb begin
        score_color = COLOR_SAFE;
        if (state == CD_DONE && alarmed)
            score_color = COLOR_EXPIRED;
        else if (time_left < SEC_W'(16))
            score_color = {4'hF - time_left[3:0], time_left[3:0], 4'h6};
    end

endmodule
